// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter between instruction fetch and the LSU,
// LSU-first with a starvation bound for fetch and flush-aware fetch responses.
module mem_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_v_i,
    input  logic [XLEN-1:0] if_adr_i,
    input  logic            flush_i,
    output logic            if_gnt_o,
    output logic            if_rsp_v_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            lsu_req_v_i,
    input  logic [XLEN-1:0] lsu_adr_i,
    input  logic            lsu_is_store_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [2:0]      lsu_size_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rsp_v_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            stall_o,
    output logic            mem_req_v_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_ready_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSU} state_t;
    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_starve;
    logic            r_drop, r_we, r_if_rsp_v, r_lsu_rsp_v;
    logic [XLEN-1:0] r_adr, r_wdata, r_if_rdata, r_lsu_rdata;
    logic [2:0]      r_size;
    logic            w_busy, w_done, w_arb, w_fetch_ok, w_fetch_pri;
    logic            w_if_gnt, w_lsu_gnt, w_if_rsp, w_lsu_rsp;

    always_ff @(posedge clk) r_state <= reset_n ? w_state_nxt : IDLE;

    // Arbitration happens when idle or in the completion cycle, so a waiting
    // requester follows the previous transaction with no bubble.
    always_comb begin
        w_busy      = r_state != IDLE;
        w_done      = w_busy & mem_ready_i;
        w_arb       = reset_n & (~w_busy | mem_ready_i);
        w_fetch_ok  = if_req_v_i & ~flush_i;
        w_fetch_pri = r_starve == SW'(STARVE_LIM);
        w_if_gnt    = w_arb & w_fetch_ok & (~lsu_req_v_i | w_fetch_pri);
        w_lsu_gnt   = w_arb & lsu_req_v_i & ~(w_fetch_ok & w_fetch_pri);
        w_if_rsp    = w_done & (r_state == BUSY_IF) & ~(r_drop | flush_i);
        w_lsu_rsp   = w_done & (r_state == BUSY_LSU);
        w_state_nxt = w_if_gnt ? BUSY_IF : w_lsu_gnt ? BUSY_LSU : w_done ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve    <= '0;
            r_drop      <= 1'b0;
            r_adr       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_size      <= 3'b000;
            r_if_rsp_v  <= 1'b0;
            r_if_rdata  <= '0;
            r_lsu_rsp_v <= 1'b0;
            r_lsu_rdata <= '0;
        end else begin
            r_starve    <= (w_if_gnt | ~if_req_v_i) ? '0 :
                           (flush_i | w_fetch_pri) ? r_starve : r_starve + 1'b1;
            r_drop      <= (r_state == BUSY_IF) & ~mem_ready_i & (r_drop | flush_i);
            r_adr       <= w_if_gnt ? if_adr_i : w_lsu_gnt ? lsu_adr_i : w_done ? '0 : r_adr;
            r_we        <= w_if_gnt ? 1'b0 : w_lsu_gnt ? lsu_is_store_i : w_done ? 1'b0 : r_we;
            r_wdata     <= w_if_gnt ? '0 : w_lsu_gnt ? lsu_wdata_i : w_done ? '0 : r_wdata;
            r_size      <= w_if_gnt ? 3'b010 : w_lsu_gnt ? lsu_size_i : w_done ? 3'b000 : r_size;
            r_if_rsp_v  <= w_if_rsp;
            r_if_rdata  <= w_if_rsp ? mem_rdata_i : '0;
            r_lsu_rsp_v <= w_lsu_rsp;
            r_lsu_rdata <= (w_lsu_rsp & ~r_we) ? mem_rdata_i : '0;
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign lsu_gnt_o   = w_lsu_gnt;
    assign stall_o     = lsu_req_v_i & ~w_lsu_gnt;
    assign if_rsp_v_o  = r_if_rsp_v;
    assign if_rdata_o  = r_if_rdata;
    assign lsu_rsp_v_o = r_lsu_rsp_v;
    assign lsu_rdata_o = r_lsu_rdata;
    assign mem_req_v_o = w_busy;
    assign mem_adr_o   = r_adr;
    assign mem_we_o    = r_we;
    assign mem_wdata_o = r_wdata;
    assign mem_size_o  = r_size;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized requesters and memory against a transaction-level
// model; responses are checked by a separate scoreboard monitor.
module tb_mem_arb;
    localparam int LIM = 4;
    logic        clk = 0, reset_n, if_req_v_i, flush_i, lsu_req_v_i, lsu_is_store_i, mem_ready_i;
    logic [31:0] if_adr_i, lsu_adr_i, lsu_wdata_i, mem_rdata_i;
    logic [2:0]  lsu_size_i;
    logic        if_gnt_o, if_rsp_v_o, lsu_gnt_o, lsu_rsp_v_o, stall_o, mem_req_v_o, mem_we_o;
    logic [31:0] if_rdata_o, lsu_rdata_o, mem_adr_o, mem_wdata_o;
    logic [2:0]  mem_size_o;

    mem_arb #(.XLEN(32), .STARVE_LIM(LIM)) dut (
        .clk(clk), .reset_n(reset_n), .if_req_v_i(if_req_v_i), .if_adr_i(if_adr_i),
        .flush_i(flush_i), .if_gnt_o(if_gnt_o), .if_rsp_v_o(if_rsp_v_o), .if_rdata_o(if_rdata_o),
        .lsu_req_v_i(lsu_req_v_i), .lsu_adr_i(lsu_adr_i), .lsu_is_store_i(lsu_is_store_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_size_i(lsu_size_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rsp_v_o(lsu_rsp_v_o), .lsu_rdata_o(lsu_rdata_o), .stall_o(stall_o),
        .mem_req_v_o(mem_req_v_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {int unsigned due; logic [31:0] data;} rsp_t;
    rsp_t q_if[$], q_lsu[$];
    int checks = 0, errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: a response must appear exactly in its due cycle.
    initial forever begin
        @(negedge clk);
        #1;
        begin
            logic ev;
            logic [31:0] ed;
            ev = q_if.size() > 0 && q_if[0].due == cyc;
            ed = ev ? q_if[0].data : 32'h0;
            if (ev) void'(q_if.pop_front());
            chk("if_rsp_v", if_rsp_v_o, ev);
            chk("if_rdata", if_rdata_o, ed);
            ev = q_lsu.size() > 0 && q_lsu[0].due == cyc;
            ed = ev ? q_lsu[0].data : 32'h0;
            if (ev) void'(q_lsu.pop_front());
            chk("lsu_rsp_v", lsu_rsp_v_o, ev);
            chk("lsu_rdata", lsu_rdata_o, ed);
        end
    end

    logic        if_pend = 0, lsu_pend = 0, busy = 0, cur_lsu, cur_we, cur_drop;
    logic        lsu_we, flush, rdy, rst_now, arb, fetch_wins, exp_if, exp_lsu;
    logic [31:0] if_adr, lsu_adr, lsu_wd, cur_adr, cur_wd;
    logic [2:0]  lsu_sz, cur_sz;
    int          wt, starve = 0;

    initial begin
        reset_n = 0; if_req_v_i = 0; if_adr_i = 0; flush_i = 0; lsu_req_v_i = 0;
        lsu_adr_i = 0; lsu_is_store_i = 0; lsu_wdata_i = 0; lsu_size_i = 0;
        mem_ready_i = 0; mem_rdata_i = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req_v", mem_req_v_o, 0);
        chk("rst_mem_adr", mem_adr_o, 0);
        chk("rst_mem_size", mem_size_o, 0);
        chk("rst_gnts", {if_gnt_o, lsu_gnt_o}, 0);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_now = (n % 500) == 499;
            if (!if_pend && n < 2950 && $urandom_range(99) < 60) begin
                if_pend = 1;
                if_adr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_pend && n < 2950 && ((n / 1000) == 1 || $urandom_range(99) < 50)) begin
                lsu_pend = 1;
                lsu_we = 1'($urandom_range(1));
                lsu_adr = $urandom;
                lsu_wd = $urandom;
                lsu_sz = 3'($urandom_range(2));
            end
            flush = $urandom_range(99) < 15;
            rdy = busy ? (wt == 0) : 1'($urandom_range(1));
            reset_n = !rst_now;
            if_req_v_i = if_pend; if_adr_i = if_adr; flush_i = flush;
            lsu_req_v_i = lsu_pend; lsu_adr_i = lsu_adr; lsu_is_store_i = lsu_we;
            lsu_wdata_i = lsu_wd; lsu_size_i = lsu_sz;
            mem_ready_i = rdy;
            mem_rdata_i = (busy && rdy) ? mem_f(cur_adr) : $urandom;
            #1;
            chk("mem_req_v", mem_req_v_o, busy);
            chk("mem_adr", mem_adr_o, busy ? cur_adr : 0);
            chk("mem_we", mem_we_o, busy ? cur_we : 0);
            chk("mem_wdata", mem_wdata_o, busy ? cur_wd : 0);
            chk("mem_size", mem_size_o, busy ? cur_sz : 0);
            arb = !rst_now && (!busy || rdy);
            fetch_wins = if_pend && !flush && (!lsu_pend || starve == LIM);
            exp_if = arb && fetch_wins;
            exp_lsu = arb && lsu_pend && !fetch_wins;
            chk("if_gnt", if_gnt_o, exp_if);
            chk("lsu_gnt", lsu_gnt_o, exp_lsu);
            chk("stall", stall_o, lsu_pend && !exp_lsu);
            if (rst_now) begin
                busy = 0;
                starve = 0;
            end else begin
                if (busy && !cur_lsu && flush) cur_drop = 1;
                if (busy && rdy) begin
                    if (cur_lsu) q_lsu.push_back('{cyc + 1, cur_we ? 32'h0 : mem_f(cur_adr)});
                    else if (!cur_drop) q_if.push_back('{cyc + 1, mem_f(cur_adr)});
                    busy = 0;
                end else if (busy) wt--;
                if (exp_if || !if_pend) starve = 0;
                else if (!flush && starve < LIM) starve++;
                if (exp_if || exp_lsu) begin
                    busy = 1;
                    cur_lsu = exp_lsu;
                    cur_adr = exp_lsu ? lsu_adr : if_adr;
                    cur_we = exp_lsu && lsu_we;
                    cur_wd = exp_lsu ? lsu_wd : 32'h0;
                    cur_sz = exp_lsu ? lsu_sz : 3'b010;
                    cur_drop = 0;
                    wt = $urandom_range(3);
                end
                if (exp_if) if_pend = 0;
                if (exp_lsu) lsu_pend = 0;
            end
        end
        @(negedge clk);
        if_req_v_i = 0; lsu_req_v_i = 0; mem_ready_i = 0;
        @(negedge clk);
        #2;
        chk("q_if_drained", q_if.size(), 0);
        chk("q_lsu_drained", q_lsu.size(), 0);
        chk("end_idle", mem_req_v_o, busy);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be: XLEN, default 32 (from riscv_pkg), data/address width; STARVE_LIM, default 4, count of consecutive fetch-denied cycles that forces fetch priority.
REQ-002 Ports SHALL be:
- clk  in  1  clock, single domain
- reset_n  in  1  synchronous active-low reset
- if_req_v_i  in  1  fetch request valid
- if_adr_i  in  XLEN  fetch address
- flush_i  in  1  pipeline flush (branch taken)
- if_gnt_o  out  1  fetch request accepted
- if_rsp_v_o  out  1  fetch data valid
- if_rdata_o  out  XLEN  fetch data
- lsu_req_v_i  in  1  load/store request valid
- lsu_adr_i  in  XLEN  load/store address
- lsu_is_store_i  in  1  1 = store
- lsu_wdata_i  in  XLEN  store data
- lsu_size_i  in  3  access size
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rsp_v_o  out  1  LSU transaction done
- lsu_rdata_o  out  XLEN  load data
- stall_o  out  1  LSU requesting but not granted
- mem_req_v_o  out  1  memory request valid
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  XLEN  memory write data
- mem_size_o  out  3  memory access size
- mem_ready_i  in  1  memory completes current request this cycle
- mem_rdata_i  in  XLEN  read data, valid with mem_ready_i

Function
REQ-003 FSM states SHALL be IDLE, BUSY_IF, BUSY_LSU; one memory transaction outstanding at most.
REQ-004 Arbitration SHALL occur in IDLE, or in BUSY_* in the cycle mem_ready_i=1 (back-to-back, no idle bubble).
REQ-005 Priority: LSU over fetch, except starve counter == STARVE_LIM gives fetch priority.
REQ-006 Fetch SHALL NOT be granted in a cycle with flush_i=1.
REQ-007 On grant: gnt_o pulse 1 cycle; address/we/wdata/size registered; state -> BUSY_x next cycle.
REQ-008 Requesters hold req_v and payload until gnt; unaccepted requests need no storage in mem_arb.
REQ-009 In BUSY_x, mem_req_v_o=1 with registered payload held stable until mem_ready_i=1; in IDLE, mem_req_v_o=0 and all mem_* outputs 0.
REQ-010 Fetch transactions: mem_we_o=0, mem_wdata_o=0, mem_size_o=3'b010 (word).
REQ-011 Latency: gnt cycle T -> mem_req_v_o at T+1 -> mem_ready_i at T+k (k>=1) -> rsp_v_o pulse at T+k+1, data registered from mem_rdata_i.
REQ-012 lsu_rsp_v_o SHALL pulse for loads and stores; lsu_rdata_o=0 for stores.
REQ-013 rsp outputs SHALL be 0 in cycles without rsp_v pulse.
REQ-014 Starve counter: +1 each cycle if_req_v_i=1 and fetch not granted and flush_i=0, saturating at STARVE_LIM; cleared on fetch grant or if_req_v_i=0.
REQ-015 Flush while BUSY_IF: transaction SHALL complete at memory (mem_req_v_o held); if_rsp_v_o suppressed for it via drop flag, cleared at completion.
REQ-016 Flush SHALL NOT affect LSU transactions or LSU grants.
REQ-017 stall_o = lsu_req_v_i & ~lsu_gnt_o (combinational).
REQ-018 mem_ready_i in IDLE SHALL be ignored.

Reset
REQ-019 reset_n=0 at a clock edge: state IDLE, starve counter 0, drop flag 0, all registered outputs 0, including mid-transaction (no response for the aborted transaction).
REQ-020 While reset_n=0, gnt outputs SHALL be 0.

Verification
REQ-021 Both req in IDLE, counter 0 -> lsu_gnt_o=1 at T, mem_req_v_o/mem_adr_o=lsu_adr_i at T+1, ready at T+3 -> lsu_rsp_v_o at T+4.
REQ-022 LSU load/store back-to-back 6 times with fetch pending, STARVE_LIM=4 -> fetch granted at 5th arbitration despite lsu_req_v_i=1; counter returns 0.
REQ-023 Fetch adr 0x100 granted, flush_i=1 at T+1, ready at T+2 -> no if_rsp_v_o; mem_req_v_o held until ready.
REQ-024 Store adr 0x200, wdata 0xDEADBEEF, size 3'b001 -> mem_we_o=1, payload stable across 3 wait cycles; lsu_rsp_v_o pulse, lsu_rdata_o=0.
REQ-025 reset_n=0 during BUSY_LSU -> next cycle IDLE, mem_req_v_o=0, no lsu_rsp_v_o.
REQ-026 mem_ready_i=1 in completion cycle with fetch waiting -> if_gnt_o same cycle, mem_req_v_o stays 1 with new adr next cycle.
